// File: rtl/audio_adc_deserializer_if.sv
// Codec ADC serial inputs and parallel sample outputs of the deserializer.
// The master side is the deserializer; the slave side is the codec/consumer.
interface audio_adc_deserializer_if #(
    parameter int AUDIO_DATA_WIDTH = 24
);
    logic                        bclk;
    logic                        adclrck;
    logic                        adcdat;
    logic [AUDIO_DATA_WIDTH-1:0] left_sample;
    logic                        left_valid;
    logic [AUDIO_DATA_WIDTH-1:0] right_sample;
    logic                        right_valid;
    logic                        frame_error;

    modport master (
        input  bclk,
        input  adclrck,
        input  adcdat,
        output left_sample,
        output left_valid,
        output right_sample,
        output right_valid,
        output frame_error
    );

    modport slave (
        output bclk,
        output adclrck,
        output adcdat,
        input  left_sample,
        input  left_valid,
        input  right_sample,
        input  right_valid,
        input  frame_error
    );
endinterface

// File: rtl/audio_adc_deserializer.sv
// Codec ADC serial stream (I2S or left-justified) to parallel samples in clk.
// BCLK/LRCK/DAT are synchronized; BCLK rising edges are detected after sync.
module audio_adc_deserializer #(
    parameter int AUDIO_DATA_WIDTH = 24,
    parameter bit I2S_MODE         = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    audio_adc_deserializer_if.master bus
);
    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    logic [2:0]    r_bclk_sync;
    logic [2:0]    r_lrck_sync;
    logic [2:0]    r_dat_sync;

    state_t        r_state;
    logic [W-1:0]  r_shift;
    logic [CW-1:0] r_cnt;
    logic          r_seen;
    logic          r_prev_lrck;
    logic          r_chan_left;
    logic [W-1:0]  r_word;
    logic          r_done_l;
    logic          r_done_r;
    logic [W-1:0]  r_left_sample;
    logic          r_left_valid;
    logic [W-1:0]  r_right_sample;
    logic          r_right_valid;
    logic          r_ferr;

    logic          w_bedge;
    logic          w_lrck;
    logic          w_dat;
    logic          w_event;
    logic          w_new_left;
    logic          w_last;
    logic [W-1:0]  w_shift_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[1:0], bus.bclk};
            r_lrck_sync <= {r_lrck_sync[1:0], bus.adclrck};
            r_dat_sync  <= {r_dat_sync[1:0], bus.adcdat};
        end
    end

    assign w_bedge      = r_bclk_sync[1] & ~r_bclk_sync[2];
    assign w_lrck       = r_lrck_sync[2];
    assign w_dat        = r_dat_sync[2];
    // No LRCK history exists before the first edge after reset.
    assign w_event      = r_seen & (w_lrck != r_prev_lrck);
    assign w_new_left   = I2S_MODE ? ~w_lrck : w_lrck;
    assign w_last       = (r_cnt == LAST);
    assign w_shift_next = {r_shift[W-2:0], w_dat};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_cnt          <= '0;
            r_seen         <= 1'b0;
            r_prev_lrck    <= 1'b0;
            r_chan_left    <= 1'b0;
            r_word         <= '0;
            r_done_l       <= 1'b0;
            r_done_r       <= 1'b0;
            r_left_sample  <= '0;
            r_left_valid   <= 1'b0;
            r_right_sample <= '0;
            r_right_valid  <= 1'b0;
            r_ferr         <= 1'b0;
        end else begin
            r_done_l      <= 1'b0;
            r_done_r      <= 1'b0;
            r_ferr        <= 1'b0;
            r_left_valid  <= r_done_l;
            r_right_valid <= r_done_r;
            if (r_done_l) r_left_sample <= r_word;
            if (r_done_r) r_right_sample <= r_word;

            if (w_bedge) begin
                r_seen      <= 1'b1;
                r_prev_lrck <= w_lrck;
                if (w_event) begin
                    r_chan_left <= w_new_left;
                    r_state     <= SHIFT;
                    if (I2S_MODE) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt   <= ONE;
                        r_shift <= w_shift_next;
                    end
                    // In I2S the old word's LSB can arrive on the LRCK edge.
                    if (r_state == SHIFT) begin
                        if (I2S_MODE && w_last) begin
                            r_word   <= w_shift_next;
                            r_done_l <= r_chan_left;
                            r_done_r <= ~r_chan_left;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end
                end else begin
                    unique case (r_state)
                        SHIFT: begin
                            r_shift <= w_shift_next;
                            r_cnt   <= r_cnt + ONE;
                            if (w_last) begin
                                r_word   <= w_shift_next;
                                r_done_l <= r_chan_left;
                                r_done_r <= ~r_chan_left;
                                r_state  <= HOLD;
                            end
                        end
                        IDLE, HOLD: begin
                            r_state <= r_state;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.left_sample  = r_left_sample;
    assign bus.left_valid   = r_left_valid;
    assign bus.right_sample = r_right_sample;
    assign bus.right_valid  = r_right_valid;
    assign bus.frame_error  = r_ferr;
endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Scoreboard bench: one I2S and one left-justified deserializer instance.
// Stimulus queues expected words; a negedge monitor pops and compares.
module tb_audio_adc_deserializer;
    typedef struct packed {
        logic        left;
        logic [23:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   ferr_cnt [2];
    exp_t qa [$];
    exp_t qb [$];
    int   vcyc_b [$];
    int   rise_cyc [$];
    logic lq [$];
    logic dq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    audio_adc_deserializer_if #(.AUDIO_DATA_WIDTH(24)) bus_a ();
    audio_adc_deserializer_if #(.AUDIO_DATA_WIDTH(24)) bus_b ();

    audio_adc_deserializer #(
        .AUDIO_DATA_WIDTH(24),
        .I2S_MODE(1'b1)
    ) dut_a (
        .clk(clk),
        .reset_n(rst_n),
        .bus(bus_a)
    );

    audio_adc_deserializer #(
        .AUDIO_DATA_WIDTH(24),
        .I2S_MODE(1'b0)
    ) dut_b (
        .clk(clk),
        .reset_n(rst_n),
        .bus(bus_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic mon(input int m, input logic lv, input logic rv,
                       input logic [23:0] ls, input logic [23:0] rs,
                       input logic fe);
        exp_t e;
        logic [23:0] got;
        int   qs;
        if (fe) ferr_cnt[m]++;
        if (lv && rv) begin
            total++;
            bad++;
            $display("FAIL both_valid dut=%0d got both required one", m);
        end
        if (lv || rv) begin
            if (m == 1) vcyc_b.push_back(cyc);
            qs  = (m == 0) ? qa.size() : qb.size();
            got = lv ? ls : rs;
            total++;
            if (qs == 0) begin
                bad++;
                $display("FAIL unexpected_valid dut=%0d got left=%0b %h required none",
                         m, lv, got);
            end else begin
                if (m == 0) e = qa.pop_front();
                else        e = qb.pop_front();
                if (e.left !== lv || e.v !== got) begin
                    bad++;
                    $display("FAIL word dut=%0d got left=%0b %h required left=%0b %h",
                             m, lv, got, e.left, e.v);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.left_valid, bus_a.right_valid, bus_a.left_sample,
            bus_a.right_sample, bus_a.frame_error);
        mon(1, bus_b.left_valid, bus_b.right_valid, bus_b.left_sample,
            bus_b.right_sample, bus_b.frame_error);
    end

    task automatic drive(input int m, input logic b, input logic lr,
                         input logic d);
        if (m == 0) begin
            bus_a.bclk = b; bus_a.adclrck = lr; bus_a.adcdat = d;
        end else begin
            bus_b.bclk = b; bus_b.adclrck = lr; bus_b.adcdat = d;
        end
    endtask

    // One BCLK period: data/LRCK change while BCLK is low, 4 clk per half.
    task automatic put_bit(input int m, input logic lr, input logic d);
        drive(m, 1'b0, lr, d);
        repeat (4) @(negedge clk);
        drive(m, 1'b1, lr, d);
        rise_cyc.push_back(cyc);
        repeat (4) @(negedge clk);
        drive(m, 1'b0, lr, d);
    endtask

    task automatic add_slot(input logic lr, input logic [23:0] w,
                            input int first, input int nw, input int len,
                            input logic pad);
        int idx;
        for (int i = 0; i < len; i++) begin
            idx = first + i;
            lq.push_back(lr);
            if (idx < nw) dq.push_back(w[23 - idx]);
            else          dq.push_back(pad);
        end
    endtask

    // I2S data lags LRCK by one BCLK.
    task automatic play(input int m, input int n);
        logic d;
        for (int i = 0; i < n; i++) begin
            if (m == 1)      d = dq[i];
            else if (i == 0) d = 1'b0;
            else             d = dq[i - 1];
            put_bit(m, lq[i], d);
        end
    endtask

    task automatic expect_word(input int m, input logic left,
                               input logic [23:0] v);
        exp_t e;
        e.left = left;
        e.v    = v;
        if (m == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic check_zero(input int m, input string tag);
        if (m == 0) begin
            chk({tag, "_rst_left"}, {8'h0, bus_a.left_sample}, 32'h0);
            chk({tag, "_rst_right"}, {8'h0, bus_a.right_sample}, 32'h0);
            chk({tag, "_rst_flags"}, {29'h0, bus_a.left_valid,
                bus_a.right_valid, bus_a.frame_error}, 32'h0);
        end else begin
            chk({tag, "_rst_left"}, {8'h0, bus_b.left_sample}, 32'h0);
            chk({tag, "_rst_right"}, {8'h0, bus_b.right_sample}, 32'h0);
            chk({tag, "_rst_flags"}, {29'h0, bus_b.left_valid,
                bus_b.right_valid, bus_b.frame_error}, 32'h0);
        end
    endtask

    task automatic do_reset(input int m, input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        lq.delete();
        dq.delete();
        rise_cyc.delete();
        vcyc_b.delete();
        qa.delete();
        qb.delete();
        repeat (3) @(negedge clk);
        check_zero(m, tag);
        rst_n = 1'b1;
        ferr_cnt[0] = 0;
        ferr_cnt[1] = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input int m, input string tag);
        int qs;
        qs = (m == 0) ? qa.size() : qb.size();
        for (int i = 0; i < 40 && qs != 0; i++) begin
            @(negedge clk);
            qs = (m == 0) ? qa.size() : qb.size();
        end
        repeat (8) @(negedge clk);
        qs = (m == 0) ? qa.size() : qb.size();
        chk({tag, "_pending"}, qs, 0);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        ferr_cnt[0] = 0;
        ferr_cnt[1] = 0;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);

        // I2S basic stereo frame, zero padding
        do_reset(0, "i2s");
        add_slot(1'b1, 24'h0, 0, 0, 3, 1'b0);
        add_slot(1'b0, 24'h123456, 0, 24, 32, 1'b0);
        add_slot(1'b1, 24'hFEDCBA, 0, 24, 32, 1'b0);
        add_slot(1'b0, 24'h0, 0, 0, 2, 1'b0);
        expect_word(0, 1'b1, 24'h123456);
        expect_word(0, 1'b0, 24'hFEDCBA);
        play(0, lq.size());
        drain(0, "i2s");
        chk("i2s_ferr", ferr_cnt[0], 0);
        chk("i2s_hold_left", {8'h0, bus_a.left_sample}, 32'h123456);
        chk("i2s_hold_right", {8'h0, bus_a.right_sample}, 32'hFEDCBA);

        // Pad bits of 1s beyond the word are ignored
        do_reset(0, "pad");
        add_slot(1'b1, 24'h0, 0, 0, 3, 1'b1);
        add_slot(1'b0, 24'h0F0F0F, 0, 24, 32, 1'b1);
        add_slot(1'b1, 24'h800000, 0, 24, 32, 1'b1);
        add_slot(1'b0, 24'h0, 0, 0, 2, 1'b1);
        expect_word(0, 1'b1, 24'h0F0F0F);
        expect_word(0, 1'b0, 24'h800000);
        play(0, lq.size());
        drain(0, "pad");
        chk("pad_ferr", ferr_cnt[0], 0);

        // Short left frame: error, then a clean right word
        do_reset(0, "short");
        add_slot(1'b1, 24'h0, 0, 0, 3, 1'b0);
        add_slot(1'b0, 24'hABCDEF, 0, 24, 10, 1'b0);
        add_slot(1'b1, 24'h000001, 0, 24, 32, 1'b0);
        add_slot(1'b0, 24'h0, 0, 0, 2, 1'b0);
        expect_word(0, 1'b0, 24'h000001);
        play(0, lq.size());
        drain(0, "short");
        chk("short_ferr", ferr_cnt[0], 1);
        chk("short_left_kept", {8'h0, bus_a.left_sample}, 32'h0);

        // Start 7 bits into a left slot
        do_reset(0, "mid");
        add_slot(1'b0, 24'hC0FFEE, 7, 24, 25, 1'b0);
        add_slot(1'b1, 24'h654321, 0, 24, 32, 1'b0);
        add_slot(1'b0, 24'h13579B, 0, 24, 32, 1'b0);
        add_slot(1'b1, 24'h0, 0, 0, 2, 1'b0);
        expect_word(0, 1'b0, 24'h654321);
        expect_word(0, 1'b1, 24'h13579B);
        play(0, lq.size());
        drain(0, "mid");
        chk("mid_ferr", ferr_cnt[0], 0);

        // Reset at bit 12 of a word, then a fresh frame
        do_reset(0, "rmw_a");
        add_slot(1'b1, 24'h0, 0, 0, 3, 1'b0);
        add_slot(1'b0, 24'h7FFFFF, 0, 24, 32, 1'b0);
        add_slot(1'b1, 24'h000100, 0, 24, 32, 1'b0);
        add_slot(1'b0, 24'hAAAAAA, 0, 24, 32, 1'b0);
        expect_word(0, 1'b1, 24'h7FFFFF);
        expect_word(0, 1'b0, 24'h000100);
        play(0, 3 + 32 + 32 + 13);
        drain(0, "rmw_a");
        chk("rmw_pre_right", {8'h0, bus_a.right_sample}, 32'h000100);
        do_reset(0, "rmw_b");
        add_slot(1'b1, 24'h0, 0, 0, 3, 1'b0);
        add_slot(1'b0, 24'h112233, 0, 24, 32, 1'b0);
        add_slot(1'b1, 24'h445566, 0, 24, 32, 1'b0);
        add_slot(1'b0, 24'h0, 0, 0, 2, 1'b0);
        expect_word(0, 1'b1, 24'h112233);
        expect_word(0, 1'b0, 24'h445566);
        play(0, lq.size());
        drain(0, "rmw_b");
        chk("rmw_ferr", ferr_cnt[0], 0);

        // Left-justified: LRCK high = left, MSB on the edge
        do_reset(1, "lj");
        add_slot(1'b0, 24'h0, 0, 0, 3, 1'b0);
        add_slot(1'b1, 24'h123456, 0, 24, 32, 1'b0);
        add_slot(1'b0, 24'hFEDCBA, 0, 24, 32, 1'b0);
        add_slot(1'b1, 24'h0, 0, 0, 2, 1'b0);
        expect_word(1, 1'b1, 24'h123456);
        expect_word(1, 1'b0, 24'hFEDCBA);
        play(1, lq.size());
        drain(1, "lj");
        chk("lj_ferr", ferr_cnt[1], 0);
        chk("lj_nvalid", vcyc_b.size(), 2);
        if (vcyc_b.size() > 0)
            chk("lj_latency", vcyc_b[0] - rise_cyc[3 + 23], 4);

        // Left-justified short frame
        do_reset(1, "ljs");
        add_slot(1'b0, 24'h0, 0, 0, 3, 1'b0);
        add_slot(1'b1, 24'h555555, 0, 24, 5, 1'b0);
        add_slot(1'b0, 24'h000001, 0, 24, 32, 1'b0);
        add_slot(1'b1, 24'h0, 0, 0, 2, 1'b0);
        expect_word(1, 1'b0, 24'h000001);
        play(1, lq.size());
        drain(1, "ljs");
        chk("ljs_ferr", ferr_cnt[1], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/audio_adc_deserializer.md
Name: audio_adc_deserializer

Overview:
Upstream capture stage for the audio filter chain. Receives the codec ADC serial stream (BCLK, ADCLRCK, ADCDAT; codec is bus master) and reassembles it into signed parallel samples in the `clk` domain. The block drives one parallel sample and a one-cycle valid pulse per channel. The valid pulse connects directly to the filter's `enable`, and the sample connects to its `signal` input.

Parameters:
AUDIO_DATA_WIDTH, 24, bits per sample word, MSB first.
I2S_MODE, 1, 1 = I2S framing (MSB one BCLK after the LRCK edge, LRCK low = left); 0 = left-justified (MSB on the LRCK edge, LRCK high = left).

Ports:
clk  input  1  system clock; must be at least 4x the BCLK frequency.
reset_n  input  1  reset, asynchronous, active-low.
bclk  input  1  codec bit clock, asynchronous to clk.
adclrck  input  1  codec ADC left/right clock, asynchronous.
adcdat  input  1  codec ADC serial data, asynchronous.
left_sample  output  AUDIO_DATA_WIDTH  last complete left word, two's complement.
left_valid  output  1  one-clk pulse when left_sample updates.
right_sample  output  AUDIO_DATA_WIDTH  last complete right word.
right_valid  output  1  one-clk pulse when right_sample updates.
frame_error  output  1  one-clk pulse when a word is truncated by an early LRCK edge.

Behaviour:
- Reset (asynchronous assert, deassert on clk): samples = 0, valids = 0, frame_error = 0, shift register = 0, bit count = 0, state = IDLE, all synchronizers = 0.
- Synchronization:
  - bclk, adclrck and adcdat each pass through a 2-FF synchronizer, then one more register stage (s3).
  - A BCLK rising edge ("bedge") is s2 = 1 and s3 = 0, a single clk cycle.
  - Data and LRCK are taken from s3 on bedge. The codec changes them on the BCLK falling edge, so they are stable.
- LRCK event: on a bedge, the sampled LRCK differs from the LRCK sampled at the previous bedge.
  - The new channel is taken from the new LRCK level according to I2S_MODE.
- States:
  - IDLE: ignore data until the first LRCK event, so a partial word after reset is never emitted.
  - SHIFT: on each bedge, shift the data bit into the LSB of the shift register and increment the count. When count reaches AUDIO_DATA_WIDTH, go to HOLD.
  - HOLD: the word is complete. Ignore further bits (codec slots wider than the word) until the next LRCK event.
- On an LRCK event (any state), capture the channel and go to SHIFT:
  - I2S_MODE = 1: count := 0 and the bit on this bedge is discarded (it is the previous slot's pad or LSB).
  - I2S_MODE = 0: this bedge's bit is the MSB and count := 1.
- Short frame: an LRCK event while in SHIFT with count < AUDIO_DATA_WIDTH:
  - frame_error pulses in the next clk cycle.
  - The partial word is discarded and no valid is raised.
  - The new word starts as above.
- Word completion:
  - On the clk cycle after the bedge that loads the last bit, the channel's sample register loads the full shift value and its valid is 1 for exactly one cycle.
  - Each sample holds until the next completed word of the same channel.
  - Latency from the BCLK pin rising edge to valid is 4 clk cycles: 2 sync, 1 s3 register, 1 output register.
- Completion and an LRCK event on the same bedge: both take effect. The completed word is emitted with no frame_error, and the new word starts.
- left_valid and right_valid are never asserted in the same cycle.
- Reset mid-word: the partial word is discarded, the block returns to IDLE, and outputs clear to 0.

Test Plan:
- I2S_MODE = 1, 32 BCLK per channel, left = 0x123456, right = 0xFEDCBA → left_sample = 0x123456 with one left_valid pulse; then right_sample = 0xFEDCBA (negative) with one right_valid pulse; frame_error stays 0.
- I2S_MODE = 0, same frames with LRCK polarity per left-justified framing → identical captured values; valid 4 clk after the LSB BCLK rising edge.
- Slot wider than the word: 24 data bits followed by 8 pad bits of 1s → sample equals the 24-bit word exactly; pad bits are ignored.
- Short frame: LRCK toggles after 10 left bits → one frame_error pulse, left_valid stays 0, and the following right word 0x000001 is captured correctly.
- Start mid-frame: stimulus begins 7 bits into a left slot after reset release → no valid until after the next LRCK event; the first emitted word is correct.
- Assert reset_n = 0 at bit 12 of a word, release, send a full frame → outputs are 0 during reset; only the post-reset full words are emitted.
